// File: rtl/console_uart_tx.sv
// console_uart_tx: byte FIFO plus 8N1 UART serializer for console output.
// Accepts bytes on a req/ack handshake and shifts them out LSB first.
//
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous active-high reset
//   i_data  - console byte, valid while i_req=1
//   i_req   - handshake request
//   o_ack   - handshake acknowledge (FIFO not full)
//   o_txd   - UART serial output, idles high
//   o_busy  - frame in progress or FIFO non-empty
//   o_level - FIFO occupancy, excluding the byte in the shifter
module console_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [7:0]                  i_data,
    input  logic                        i_req,
    output logic                        o_ack,
    output logic                        o_txd,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    state_t      r_state;
    state_t      w_state_n;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_n;
    logic [15:0] r_baud;
    logic [15:0] w_baud_n;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_n;
    logic        r_txd;
    logic        w_txd_n;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_tick;
    logic [7:0]  w_head;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_req && !w_full;
    assign w_tick  = (r_baud == 16'd0);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    assign o_ack   = !w_full;
    assign o_level = r_wptr - r_rptr;
    assign o_busy  = (r_state != S_IDLE) || !w_empty;
    assign o_txd   = r_txd;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= 8'd0;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_shift <= w_shift_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_txd   <= w_txd_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_baud_n  = r_baud;
        w_bit_n   = r_bit;
        w_pop     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_head;
                    w_baud_n  = BAUD_LOAD;
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_baud_n  = BAUD_LOAD;
                    w_bit_n   = 3'd0;
                    w_state_n = S_DATA;
                end else begin
                    w_baud_n = r_baud - 16'd1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_baud_n  = BAUD_LOAD;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_n = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_n = r_baud - 16'd1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    // Chain straight into the next start bit when more is queued.
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_n = w_head;
                        w_baud_n  = BAUD_LOAD;
                        w_state_n = S_START;
                    end else begin
                        w_baud_n  = 16'd0;
                        w_state_n = S_IDLE;
                    end
                end else begin
                    w_baud_n = r_baud - 16'd1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Line level is computed from the next state so o_txd is a plain flop.
    always_comb begin
        w_txd_n = 1'b1;
        unique case (w_state_n)
            S_START: w_txd_n = 1'b0;
            S_DATA:  w_txd_n = w_shift_n[0];
            default: w_txd_n = 1'b1;
        endcase
    end

endmodule

// File: doc/console_uart_tx.md
Name: console_uart_tx

Overview:
- Transmit end of the console send handshake that io_reg drives as o_console_data / o_console_send_hsreq, with its acknowledge on i_console_send_hsack.
- Buffers console bytes in a FIFO and serializes them on a single 8N1 UART line, so firmware console output leaves the chip instead of only reaching the simulator log.
- Sits beside io_reg in the md5calculator top level.
- Drives the acknowledge, which replaces the constant-1 tie-off.

Parameters:
- CLK_DIV, 16, clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8, byte entries in the FIFO; power of two, at least 2.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_data  input  8  console byte; valid while i_req=1.
- i_req  input  1  handshake request from io_reg (o_console_send_hsreq).
- o_ack  output  1  handshake acknowledge to io_reg (i_console_send_hsack).
- o_txd  output  1  UART serial output; idles high.
- o_busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- o_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy; excludes the byte in the shifter.

Behaviour:
- Reset (async assert, sync release): FIFO empty, o_level=0, FSM=IDLE, o_txd=1, o_busy=0, baud and bit counters=0. o_ack=1 once the FIFO is empty.
- Handshake:
  - o_ack = !fifo_full, combinational from registered FIFO state only; it never depends on i_req.
  - A byte transfers on every rising edge where i_req && o_ack. i_data is written at the write pointer.
  - A requester holding i_req high across N acked cycles transfers N bytes. io_reg deasserts i_req after its ack.
  - i_req with o_ack=0: nothing is written; i_data is ignored.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit.
  - Push and pop in the same cycle: level unchanged. This is legal only when not full, because push requires o_ack.
  - When full: a pop frees a slot the next cycle. There is no same-cycle bypass, so o_ack rises one cycle after the pop.
  - Empty FIFO with a push: the byte lands in the FIFO. The FSM pops it on the next edge; there is no write-to-shifter bypass.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_txd=1. If the FIFO is non-empty, pop into an 8-bit shift register, load baud counter=CLK_DIV-1, go to START.
  - START: o_txd=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: o_txd=shift[0], LSB first. Each bit lasts CLK_DIV cycles. After each bit, shift right and increment the index. After bit 7, go to STOP.
  - STOP: o_txd=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (zero idle gap). Otherwise go to IDLE.
- Baud counter: down-counter reloaded with CLK_DIV-1; the bit period ends at the edge where it equals 0.
- Timing: one frame = 10*CLK_DIV cycles.
- Latency: a byte accepted at edge E into an empty FIFO with the FSM in IDLE is popped at edge E+1. o_txd falls after edge E+1.
- o_txd is driven from a register, so there are no glitches.
- o_busy = (state!=IDLE) || !fifo_empty, registered-equivalent.
- Reset mid-frame: o_txd returns to 1 immediately (async). The partial frame is abandoned and FIFO contents are discarded.

Test Plan:
1. CLK_DIV=4, send 0x55 once, idle FSM → o_ack=1 throughout. o_txd falls 1 cycle after acceptance. Bit pattern 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles. o_busy drops after 40 cycles.
2. CLK_DIV=4, DEPTH=4, hold i_req with bytes 0xA5,0x01,0x02,0x03,0x04,0x05 → first byte pops, 4 fill the FIFO, o_ack=0 while full. 0x05 is accepted one cycle after the next pop. Six back-to-back frames, each exactly 40 cycles, with no idle gap.
3. i_req=1 while o_ack=0 with a changing i_data → no write occurs. o_level stays at 4, and the received stream contains no corrupted byte.
4. Wrap-around: send 20 sequential bytes 0x00..0x13 through DEPTH=4 → a bench UART receiver decodes exactly 0x00..0x13 in order. o_level never exceeds 4.
5. Assert reset for 1 cycle during bit 3 of 0xF0 with 2 bytes queued → o_txd=1 asynchronously, o_level=0, o_busy=0, o_ack=1. A subsequent byte 0x3C transmits correctly.
6. CLK_DIV=2 minimum, send 0xFF then 0x00 → bit periods are exactly 2 cycles and frames are 20 cycles. The stop-to-start transition has no extra idle cycle.
